// File: rtl/traffic_light_ctrl.sv
// Main/side-street light sequencer with optional pedestrian walk phase.
// Define TLC_WALK_EN to include the WALK state, walk_lamp and WR_Reset.
module traffic_light_ctrl #(
    parameter int T_BASE = 4,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2
) (
    input  logic       clk,
    input  logic       g_reset,
    input  logic       tick,
    input  logic       sensor_sync,
    input  logic       WR_Out,
    output logic       WR_Reset,
    output logic       main_grn,
    output logic       main_yel,
    output logic       main_red,
    output logic       side_grn,
    output logic       side_yel,
    output logic       side_red,
    output logic       walk_lamp,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        MG   = 3'd0,
        MY   = 3'd1,
        WALK = 3'd2,
        SG   = 3'd3,
        SY   = 3'd4
    } state_t;

    localparam logic [7:0] LD_BASE = 8'(T_BASE - 1);
    localparam logic [7:0] LD_EXT  = 8'(T_EXT - 1);
    localparam logic [7:0] LD_YEL  = 8'(T_YEL - 1);

`ifdef TLC_WALK_EN
    localparam logic WALK_EN = 1'b1;
`else
    localparam logic WALK_EN = 1'b0;
`endif

    state_t     state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       expire;
    logic       enter;
    logic       walk_req;

    assign expire   = tick && (count_q == 8'd0);
    // With the walk phase compiled out the request input is masked to 0.
    assign walk_req = WR_Out & WALK_EN;

    function automatic logic [7:0] load_val(input state_t s);
        case (s)
            MG:      load_val = LD_BASE;
            MY:      load_val = LD_YEL;
            WALK:    load_val = LD_EXT;
            SG:      load_val = LD_EXT;
            SY:      load_val = LD_YEL;
            default: load_val = LD_BASE;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        case (state_q)
            MG: begin
                enter = expire;
                if (expire && (sensor_sync || walk_req)) state_d = MY;
            end
            MY: begin
                enter = expire;
                if (expire) state_d = walk_req ? WALK : SG;
            end
`ifdef TLC_WALK_EN
            WALK: begin
                enter = expire;
                if (expire) state_d = sensor_sync ? SG : MG;
            end
`endif
            SG: begin
                enter = expire;
                if (expire) state_d = SY;
            end
            SY: begin
                enter = expire;
                if (expire) state_d = MG;
            end
            default: begin
                enter   = 1'b1;
                state_d = MG;
            end
        endcase

        // Every entry (including MG re-entry) reloads the full duration.
        count_d = count_q;
        if (enter)
            count_d = load_val(state_d);
        else if (tick && count_q != 8'd0)
            count_d = count_q - 8'd1;
    end

    always_ff @(posedge clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= MG;
            count_q <= LD_BASE;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

`ifdef TLC_WALK_EN
    logic wr_reset_q;

    // WALK is never re-entered from itself, so entry marks its first cycle.
    always_ff @(posedge clk or posedge g_reset) begin
        if (g_reset) wr_reset_q <= 1'b0;
        else         wr_reset_q <= enter && (state_d == WALK);
    end

    assign WR_Reset  = wr_reset_q;
    assign walk_lamp = (state_q == WALK);
`else
    assign WR_Reset  = 1'b0;
    assign walk_lamp = 1'b0;
`endif

    always_comb begin
        main_grn = 1'b0;
        main_yel = 1'b0;
        main_red = 1'b1;
        side_grn = 1'b0;
        side_yel = 1'b0;
        side_red = 1'b1;
        case (state_q)
            MG: begin
                main_grn = 1'b1;
                main_red = 1'b0;
            end
            MY: begin
                main_yel = 1'b1;
                main_red = 1'b0;
            end
            SG: begin
                side_grn = 1'b1;
                side_red = 1'b0;
            end
            SY: begin
                side_yel = 1'b1;
                side_red = 1'b0;
            end
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed table, corner sequences,
// and random stimulus against a phase/elapsed-tick reference model.
module tb_traffic_light_ctrl;

`ifdef TLC_WALK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       g_reset, tick, sensor_sync, WR_Out;
    logic       WR_Reset, main_grn, main_yel, main_red;
    logic       side_grn, side_yel, side_red, walk_lamp;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    traffic_light_ctrl dut (
        .clk         (clk),
        .g_reset     (g_reset),
        .tick        (tick),
        .sensor_sync (sensor_sync),
        .WR_Out      (WR_Out),
        .WR_Reset    (WR_Reset),
        .main_grn    (main_grn),
        .main_yel    (main_yel),
        .main_red    (main_red),
        .side_grn    (side_grn),
        .side_yel    (side_yel),
        .side_red    (side_red),
        .walk_lamp   (walk_lamp),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Reference model: phase number and ticks already consumed in that phase.
    int m_ph, m_el;
    bit m_wrr;

    function automatic int dur(input int ph);
        case (ph)
            0:       dur = 4;
            1:       dur = 2;
            2:       dur = 3;
            3:       dur = 3;
            default: dur = 2;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = 0; m_el = 0; m_wrr = 1'b0;
    endtask

    task automatic model_edge();
        int nxt;
        m_wrr = 1'b0;
        if (tick) begin
            if (m_el == dur(m_ph) - 1) begin
                case (m_ph)
                    0:       nxt = (sensor_sync || (WALK_EN && WR_Out)) ? 1 : 0;
                    1:       nxt = (WALK_EN && WR_Out) ? 2 : 3;
                    2:       nxt = sensor_sync ? 3 : 0;
                    3:       nxt = 4;
                    default: nxt = 0;
                endcase
                m_wrr = (nxt == 2);
                m_ph  = nxt;
                m_el  = 0;
            end else begin
                m_el++;
            end
        end
    endtask

    function automatic logic [10:0] exp_vec();
        logic [2:0] s;
        s = 3'(m_ph);
        exp_vec = {s, m_ph == 0, m_ph == 1, m_ph >= 2,
                   m_ph == 3, m_ph == 4, m_ph <= 2, m_ph == 2, m_wrr};
    endfunction

    function automatic logic [10:0] dut_vec();
        dut_vec = {state_o, main_grn, main_yel, main_red,
                   side_grn, side_yel, side_red, walk_lamp, WR_Reset};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic step(input string nm);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check(nm, 32'(dut_vec()), 32'(exp_vec()));
    endtask

    task automatic do_reset();
        @(negedge clk);
        g_reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("reset_hold", 32'(dut_vec()), 32'(exp_vec()));
        g_reset = 1'b0;
        #1;
        check("reset_release", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    typedef struct {
        logic       sensor;
        logic       wr;
        logic       tk;
        logic [2:0] st;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int len, walks, wrrs;
        bit found, first, req;
        logic [2:0] prev;

        tbl = '{
            '{1'b1, 1'b0, 1'b1, 3'd0}, '{1'b1, 1'b0, 1'b1, 3'd0},
            '{1'b1, 1'b0, 1'b1, 3'd0}, '{1'b1, 1'b0, 1'b1, 3'd1},
            '{1'b1, 1'b0, 1'b1, 3'd1}, '{1'b1, 1'b0, 1'b1, 3'd3},
            '{1'b1, 1'b0, 1'b1, 3'd3}, '{1'b1, 1'b0, 1'b1, 3'd3},
            '{1'b1, 1'b0, 1'b1, 3'd4}, '{1'b1, 1'b0, 1'b1, 3'd4},
            '{1'b1, 1'b0, 1'b1, 3'd0}
        };

        g_reset = 1'b1; tick = 1'b1; sensor_sync = 1'b0; WR_Out = 1'b0;
        model_reset();

        // No demand: MG held.
        do_reset();
        for (int i = 0; i < 20; i++) step("no_demand");

        // Side demand, directed table (lamp set also compared to model).
        do_reset();
        for (int i = 0; i < 11; i++) begin
            sensor_sync = tbl[i].sensor; WR_Out = tbl[i].wr; tick = tbl[i].tk;
            step("side_model");
            check($sformatf("side_tbl[%0d]", i), 32'(state_o), 32'(tbl[i].st));
        end

        // Walk demand with an emulated walk register cleared by WR_Reset.
        sensor_sync = 1'b0; tick = 1'b1;
        do_reset();
        req = 1'b1; walks = 0; wrrs = 0;
        for (int i = 0; i < 16; i++) begin
            WR_Out = req;
            step("walk_model");
            if (walk_lamp) walks++;
            if (WR_Reset) begin wrrs++; req = 1'b0; end
        end
        check("walk_lamp_cycles", 32'(walks), WALK_EN ? 32'd3 : 32'd0);
        check("wr_reset_pulses",  32'(wrrs),  WALK_EN ? 32'd1 : 32'd0);
        WR_Out = 1'b0;

        // Slow tick: every 4th cycle, side demand held.
        sensor_sync = 1'b1; tick = 1'b0;
        do_reset();
        prev = state_o; len = 1; first = 1'b1;
        for (int i = 0; i < 90; i++) begin
            tick = (i % 4 == 3);
            step("slow_model");
            if (state_o == prev) len++;
            else begin
                if (prev == 3'd1) check("slow_my_len", 32'(len), 32'd8);
                if (prev == 3'd0 && !first) check("slow_mg_len", 32'(len), 32'd16);
                if (prev == 3'd0) first = 1'b0;
                prev = state_o; len = 1;
            end
        end

        // Reset in the 2nd SG cycle: async, then a full MG after release.
        tick = 1'b1; sensor_sync = 1'b1;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step("to_sg");
            found = (state_o == 3'd3);
        end
        check("reached_sg", 32'(found), 32'd1);
        step("sg_2nd");
        g_reset = 1'b1;
        model_reset();
        #1;
        check("async_reset", 32'(dut_vec()), 32'(exp_vec()));
        @(negedge clk);
        g_reset = 1'b0;
        #1;
        len = 1; found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step("post_reset");
            if (state_o == 3'd0) len++;
            else found = 1'b1;
        end
        check("mg_len_after_reset", 32'(len), 32'd4);

        // Disabled-walk idle: WR_Out alone must not leave MG (model covers both builds).
        sensor_sync = 1'b0; WR_Out = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) step("wr_only");
        WR_Out = 1'b0;

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            sensor_sync = ($urandom_range(0, 3) == 0);
            WR_Out      = ($urandom_range(0, 4) == 0);
            tick        = ($urandom_range(0, 2) != 0);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
